// File: rtl/ddr2_burst_bridge.sv
// ddr2_burst_bridge: moves pipe-in FIFO data into DDR2 (MIG port 0) in fixed
//   bursts and reads them back, in write order, into the pipe-out FIFO.
// Latency: 1 cycle IDLE->burst; write data is registered 1 cycle after ib_valid;
//   ob_we/ob_data are registered 1 cycle after p0_rd_en.
// Backpressure: no burst starts without a full burst of input words, ring space
//   (writes) or pipe-out room (reads). p0_cmd_full stalls the command phase.
//   p0_rd_empty stalls the drain phase. A burst that has started always completes.
//
// Configuration macro: BURST_STATS_EN adds the wr_bursts/rd_bursts command counters.
//
// Ports:
//   clk, rst_n                 c3_clk0 and asynchronous active-low reset
//   calib_done                 MIG calibrated; gates the start of new bursts
//   writes_en, reads_en        allow write / read bursts
//   ib_re/ib_data/ib_valid/ib_count   pipe-in FIFO read side (data 1 cycle after ib_re)
//   ob_we/ob_data/ob_count     pipe-out FIFO write side
//   p0_cmd_*                   MIG command port (instr 000 = write, 001 = read)
//   p0_wr_en/p0_wr_data/p0_wr_mask    MIG write data port
//   p0_rd_en/p0_rd_data/p0_rd_empty   MIG read data port (first-word-fall-through)
//   occupancy                  bursts written to DDR2 but not yet read back
//   wr_bursts, rd_bursts       (BURST_STATS_EN only) command pulse counters
module ddr2_burst_bridge #(
    parameter int          BURST_LEN   = 32,
    parameter logic [29:0] ADDR_LIMIT  = 30'h0800_0000,
    parameter int          FIFO_DEPTH  = 1023,
    parameter int          OB_HEADROOM = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        writes_en,
    input  logic        reads_en,
    output logic        ib_re,
    input  logic [31:0] ib_data,
    input  logic        ib_valid,
    input  logic [9:0]  ib_count,
    output logic        ob_we,
    output logic [31:0] ob_data,
    input  logic [9:0]  ob_count,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        p0_wr_en,
    output logic [31:0] p0_wr_data,
    output logic [3:0]  p0_wr_mask,
    output logic        p0_rd_en,
    input  logic [31:0] p0_rd_data,
    input  logic        p0_rd_empty,
`ifdef BURST_STATS_EN
    output logic [15:0] wr_bursts,
    output logic [15:0] rd_bursts,
`endif
    output logic [23:0] occupancy
);

    // Byte stride of one burst and the number of bursts the ring can hold.
    localparam logic [29:0] STEP     = 30'(BURST_LEN * 4);
    localparam logic [29:0] MAXB     = ADDR_LIMIT / STEP;
    localparam logic [9:0]  BL_WORDS = 10'(BURST_LEN);
    // Pipe-out must have room for a whole burst plus headroom before a read starts,
    // because once issued the drain cannot be throttled by the pipe-out side.
    localparam logic [9:0]  OB_LIMIT = 10'(FIFO_DEPTH - BURST_LEN - OB_HEADROOM);
    localparam logic [6:0]  BL_CNT   = 7'(BURST_LEN);
    localparam logic [6:0]  BL_LAST  = 7'(BURST_LEN - 1);

    localparam logic [2:0]  INSTR_WR = 3'b000;
    localparam logic [2:0]  INSTR_RD = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        WR_FILL,
        WR_CMD,
        RD_CMD,
        RD_DRAIN
    } state_t;

    typedef enum logic {
        OP_WRITE,
        OP_READ
    } op_t;

    state_t      state;
    op_t         last_op;
    logic [29:0] wr_addr;
    logic [29:0] rd_addr;
    logic [6:0]  issued;    // ib_re cycles in the current write burst
    logic [6:0]  pushed;    // words forwarded to the MIG write port
    logic [6:0]  popped;    // words popped from the MIG read port
    logic        wr_ok;
    logic        rd_ok;

    assign p0_cmd_bl  = 6'(BURST_LEN - 1);
    assign p0_wr_mask = 4'b0000;

    // Next burst address around the ring; the ring is a whole number of bursts,
    // so the sum lands exactly on ADDR_LIMIT when it is time to wrap.
    function automatic logic [29:0] ring_next(input logic [29:0] a);
        logic [29:0] n;
        n = a + STEP;
        return (n == ADDR_LIMIT) ? 30'd0 : n;
    endfunction

    always_comb begin
        wr_ok = calib_done && writes_en && (ib_count >= BL_WORDS)
                && ({6'd0, occupancy} < MAXB);
        rd_ok = calib_done && reads_en && (occupancy != 24'd0)
                && (ob_count <= OB_LIMIT);
    end

    // The read FIFO is first-word-fall-through, so the pop can be combinational
    // and the popped word is captured into ob_data on the same edge.
    assign p0_rd_en = (state == RD_DRAIN) && !p0_rd_empty && (popped < BL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_op          <= OP_READ;
            wr_addr          <= 30'd0;
            rd_addr          <= 30'd0;
            issued           <= 7'd0;
            pushed           <= 7'd0;
            popped           <= 7'd0;
            occupancy        <= 24'd0;
            ib_re            <= 1'b0;
            ob_we            <= 1'b0;
            ob_data          <= 32'd0;
            p0_cmd_en        <= 1'b0;
            p0_cmd_instr     <= 3'b000;
            p0_cmd_byte_addr <= 30'd0;
            p0_wr_en         <= 1'b0;
            p0_wr_data       <= 32'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            p0_cmd_en <= 1'b0;
            p0_wr_en  <= 1'b0;
            ob_we     <= p0_rd_en;
            if (p0_rd_en) begin
                ob_data <= p0_rd_data;
            end

            case (state)
                IDLE: begin
                    // With both directions eligible, alternate so neither starves.
                    if (wr_ok && (!rd_ok || last_op == OP_READ)) begin
                        state  <= WR_FILL;
                        ib_re  <= 1'b1;
                        issued <= 7'd0;
                        pushed <= 7'd0;
                    end else if (rd_ok) begin
                        state <= RD_CMD;
                    end
                end

                WR_FILL: begin
                    if (ib_re) begin
                        issued <= issued + 7'd1;
                        if (issued == BL_LAST) begin
                            ib_re <= 1'b0;
                        end
                    end
                    // Count words actually returned by the pipe-in FIFO, not
                    // requests, so the command is only issued once all data is in.
                    if (ib_valid && pushed < BL_CNT) begin
                        p0_wr_en   <= 1'b1;
                        p0_wr_data <= ib_data;
                        pushed     <= pushed + 7'd1;
                        if (pushed == BL_LAST) begin
                            state <= WR_CMD;
                        end
                    end
                end

                WR_CMD: begin
                    if (!p0_cmd_full) begin
                        p0_cmd_en        <= 1'b1;
                        p0_cmd_instr     <= INSTR_WR;
                        p0_cmd_byte_addr <= wr_addr;
                        wr_addr          <= ring_next(wr_addr);
                        occupancy        <= occupancy + 24'd1;
                        last_op          <= OP_WRITE;
                        state            <= IDLE;
                    end
                end

                RD_CMD: begin
                    if (!p0_cmd_full) begin
                        p0_cmd_en        <= 1'b1;
                        p0_cmd_instr     <= INSTR_RD;
                        p0_cmd_byte_addr <= rd_addr;
                        popped           <= 7'd0;
                        state            <= RD_DRAIN;
                    end
                end

                RD_DRAIN: begin
                    if (p0_rd_en) begin
                        popped <= popped + 7'd1;
                        if (popped == BL_LAST) begin
                            rd_addr   <= ring_next(rd_addr);
                            occupancy <= occupancy - 24'd1;
                            last_op   <= OP_READ;
                            state     <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BURST_STATS_EN
    // Counters advance on the same edge that launches the matching command pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bursts <= 16'd0;
            rd_bursts <= 16'd0;
        end else begin
            if (state == WR_CMD && !p0_cmd_full) begin
                wr_bursts <= wr_bursts + 16'd1;
            end
            if (state == RD_CMD && !p0_cmd_full) begin
                rd_bursts <= rd_bursts + 16'd1;
            end
        end
    end
`endif

endmodule
